// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, sequencer states
// and per-icode decode helpers.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_e;

  // Instructions that touch data memory
  function automatic logic is_mem(input logic [3:0] icode);
    return (icode == I_RMMOV) || (icode == I_MRMOV) || (icode == I_CALL) ||
           (icode == I_RET)   || (icode == I_PUSH)  || (icode == I_POP);
  endfunction

  function automatic logic valid_ifun(input logic [3:0] icode, input logic [3:0] ifun);
    logic ok;
    ok = 1'b1;
    if (icode > I_POP) ok = 1'b0;
    else if ((icode == I_OPQ) && (ifun > 4'd3)) ok = 1'b0;
    else if (((icode == I_CMOV) || (icode == I_JXX)) && (ifun > 4'd6)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/y86_instr_check.sv
// Combinational legality and memory-class decode of the fetched icode/ifun.
module y86_instr_check
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  input  logic [3:0] ifun_i,
  output logic       ins_fault_o,
  output logic       is_mem_o
);

  assign ins_fault_o = ~valid_ifun(icode_i, ifun_i);
  assign is_mem_o    = is_mem(icode_i);

endmodule

// File: rtl/y86_seq_controller.sv
// Stage sequencer for the sequential Y86-64 core: one-hot stage enables,
// CC/RF write gating, machine status and cycle/retire counters.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic             imem_error,
  input  logic             cnd,
  input  logic             mem_ready,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             cc_we,
  output logic             rf_we,
  output logic             pc_take_jump,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [2:0]        stat_q, stat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        icode_q;
  logic              mem_q;
  logic              instr_inc;
  logic [CNT_W-1:0]  cycle_q, instr_q;
  logic              ins_fault_c, is_mem_c;

  y86_instr_check u_check (
    .icode_i     (icode),
    .ifun_i      (ifun),
    .ins_fault_o (ins_fault_c),
    .is_mem_o    (is_mem_c)
  );

  // Next-state, status and wait-counter logic
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    wait_d    = wait_q;
    instr_inc = 1'b0;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          state_d = S_HALT;
          stat_d  = STAT_ADR;
        end else if (ins_fault_c) begin
          state_d = S_HALT;
          stat_d  = STAT_INS;
        end else if (icode == I_HALT) begin
          state_d   = S_HALT;
          stat_d    = STAT_HLT;
          instr_inc = 1'b1;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_MEMORY;
        wait_d  = '0;
      end
      S_MEMORY: begin
        // mem_ready is checked before the timeout so a late response still wins
        if (!mem_q) begin
          state_d = S_WRITEBACK;
        end else if (mem_ready) begin
          if (dmem_error) begin
            state_d = S_HALT;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_HALT;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        state_d   = S_FETCH;
        instr_inc = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latches, counters and registered stage outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stat_q       <= STAT_AOK;
      wait_q       <= '0;
      icode_q      <= '0;
      mem_q        <= 1'b0;
      cycle_q      <= '0;
      instr_q      <= '0;
      fetch_en     <= 1'b0;
      decode_en    <= 1'b0;
      exec_en      <= 1'b0;
      mem_en       <= 1'b0;
      wb_en        <= 1'b0;
      pc_en        <= 1'b0;
      cc_we        <= 1'b0;
      rf_we        <= 1'b0;
      pc_take_jump <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      wait_q  <= wait_d;
      if (state_q == S_FETCH) begin
        icode_q <= icode;
        mem_q   <= is_mem_c;
      end
      if ((state_q != S_IDLE) && (state_q != S_HALT)) cycle_q <= cycle_q + CNT_W'(1);
      if (instr_inc) instr_q <= instr_q + CNT_W'(1);
      fetch_en     <= (state_d == S_FETCH);
      decode_en    <= (state_d == S_DECODE);
      exec_en      <= (state_d == S_EXECUTE);
      mem_en       <= (state_d == S_MEMORY) && mem_q;
      wb_en        <= (state_d == S_WRITEBACK);
      pc_en        <= (state_d == S_PCUPD);
      cc_we        <= (state_d == S_EXECUTE) && (icode_q == I_OPQ);
      rf_we        <= (state_d == S_WRITEBACK) && ((icode_q != I_CMOV) || cnd);
      pc_take_jump <= (state_d == S_PCUPD) &&
                      (((icode_q == I_JXX) && cnd) || (icode_q == I_CALL));
      halted       <= (state_d == S_HALT);
    end
  end

  assign stat      = stat_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

endmodule

// File: doc/y86_seq_controller.md
Name: y86_seq_controller

Overview:
- Stage sequencer for the sequential Y86-64 core.
- Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, driving a one-hot enable to each datapath stage.
- Gates condition-code writes to OPq in EXECUTE, and gates register writes by cnd for cmovq.
- Tracks machine status (AOK/HLT/ADR/INS) and keeps cycle and retired-instruction counters.

Parameters:
- CNT_W, 32, width of cycle_cnt and instr_cnt.
- MEM_TIMEOUT, 16, maximum cycles spent in MEMORY waiting for mem_ready before an ADR fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  in IDLE, begins execution at the next edge.
- icode  in  4  instruction code from the fetch stage; valid during FETCH.
- ifun  in  4  function code from the fetch stage; valid during FETCH.
- imem_error  in  1  instruction-fetch address fault; valid during FETCH.
- cnd  in  1  condition result from the execute stage; valid from EXECUTE onward.
- mem_ready  in  1  data-memory access complete.
- dmem_error  in  1  data-memory fault; sampled with mem_ready.
- fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  out  1 each  per-stage enables.
- cc_we  out  1  condition-code register write enable.
- rf_we  out  1  register-file write enable.
- pc_take_jump  out  1  PC selects valC (taken jXX).
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1  machine stopped.
- cycle_cnt  out  CNT_W  active cycles.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Reset, asynchronous at any time including mid-MEMORY:
  - State goes to IDLE.
  - All enables, cc_we, rf_we, pc_take_jump and halted are 0; stat=1 (AOK); counters are 0.
  - Internal latches and the wait counter are cleared.
- IDLE: start=1 moves to FETCH at the next edge. start is ignored in every other state.
- FETCH: fetch_en=1; icode and ifun are latched at the end of the cycle. Priority at exit:
  - imem_error -> HALT with stat=3.
  - icode>0xB, OPq(6) with ifun>3, or cmov/jXX(2/7) with ifun>6 -> HALT with stat=4.
  - icode=0 (halt) -> HALT with stat=2; instr_cnt increments.
  - Otherwise -> DECODE.
- DECODE (decode_en) -> EXECUTE. These are one-cycle states.
- EXECUTE (exec_en) -> MEMORY. One-cycle state. cc_we=1 only if the latched icode=6.
- MEMORY: mem_en=1 only for icode in {4,5,8,9,A,B}.
  - If mem_en=0: one cycle, then WRITEBACK.
  - If mem_en=1: wait until mem_ready=1.
  - mem_ready=1 with dmem_error=1 -> HALT, stat=3, no writeback.
  - mem_ready=1 with dmem_error=0 -> WRITEBACK.
  - The wait counter starts at 0 on MEMORY entry. If MEM_TIMEOUT cycles pass without mem_ready -> HALT with stat=3.
  - mem_ready together with timeout expiry in the same cycle: mem_ready wins.
- WRITEBACK: wb_en=1; rf_we = wb_en AND (icode!=2 OR cnd). Next state PCUPD.
- PCUPD: pc_en=1; pc_take_jump=1 iff icode=7 AND cnd, or icode=8 (call).
  - At exit instr_cnt increments, then back to FETCH.
  - ret (9) uses valM via the datapath; pc_take_jump=0.
- Latency: 6 cycles per instruction with no memory wait; each mem_ready wait cycle adds one.
- HALT: sticky; halted=1, all enables 0, stat holds, counters frozen. Exit only by rst.
- Enables are registered-state decodes and are mutually exclusive: at most one is high per cycle.
- cycle_cnt increments in every state except IDLE and HALT.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B.
  - Stat codes.
  - The state enum.
  - Per-icode decode functions is_mem(icode) and valid_ifun(icode, ifun).
- One sub-module is natural: y86_instr_check, combinational, producing ins_fault and is_mem from icode/ifun.

Test Plan:
- Reset, then start with icode=6, ifun=0, no waits -> enables step F,D,E,M,W,P over 6 cycles; cc_we high exactly in EXECUTE; mem_en stays 0; instr_cnt=1; cycle_cnt=6 at the next FETCH.
- icode=2, ifun=2 with cnd=0, then repeated with cnd=1 -> rf_we=0 in WRITEBACK for the first; rf_we=1 for the second; cc_we never asserts.
- icode=5 (mrmovq) with mem_ready raised 3 cycles after MEMORY entry -> MEMORY lasts 4 cycles, mem_en=1 throughout; the instruction takes 9 cycles.
- icode=0xC -> HALT after FETCH, stat=4, halted=1, instr_cnt unchanged. icode=0 -> stat=2, instr_cnt increments. A start pulse while halted has no effect.
- icode=4 with mem_ready never asserted -> HALT after 16 MEMORY cycles, stat=3. icode=A with mem_ready=1 and dmem_error=1 -> stat=3, wb_en never asserts.
- icode=7, ifun=1 with cnd=1 -> pc_take_jump=1 in PCUPD. rst pulsed mid-MEMORY -> same cycle: state IDLE, stat=1, counters 0.
